// File: rtl/st_sp_controller.sv
// rtl/st_sp_controller.sv - stack-pointer sequencer driving an external SP datapath and memory port
// Optional ack watchdog enabled by defining ST_TIMEOUT_EN.
module st_sp_controller #(
    parameter logic [31:0] SP_RESET = 32'h0000_1000
`ifdef ST_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op_sel,
    input  logic [6:0]  immed7,
    input  logic [7:0]  immed8,
    input  logic [7:0]  reg_list,
    input  logic [31:0] movsp_val,
    input  logic [31:0] dp_data_out,
    output logic [31:0] dp_data_in,
    output logic [7:0]  dp_op_sel,
    output logic [6:0]  dp_immed7,
    output logic [7:0]  dp_immed8,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_reg_idx,
    input  logic        mem_ack,
    output logic [31:0] sp,
    output logic [31:0] addr_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_PUSH = 3'd2,
        S_POP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] OP_PUSH  = 8'h01;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_ADDSP = 8'h04;
    localparam logic [7:0] OP_SUBSP = 8'h08;
    localparam logic [7:0] OP_MOVSP = 8'h10;
    localparam logic [7:0] OP_ADDS  = 8'h20;
    localparam logic [7:0] OP_LDRSP = 8'h40;
    localparam logic [7:0] OP_STRSP = 8'h80;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_sp;
    logic [31:0] r_addr;
    logic [7:0]  r_op;
    logic [6:0]  r_imm7;
    logic [7:0]  r_imm8;
    logic [7:0]  r_mask;
    logic [31:0] r_movsp;
    logic        r_err;

    logic        w_legal;
    logic        w_xfer;
    logic [2:0]  w_idx_hi;
    logic [2:0]  w_idx_lo;
    logic [2:0]  w_idx;
    logic [7:0]  w_mask_clr;
    logic        w_tmo_hit;

    // zero (NOP) or exactly one bit set
    assign w_legal    = ((op_sel & (op_sel - 8'd1)) == 8'd0);
    assign w_xfer     = (r_state == S_PUSH) || (r_state == S_POP);
    assign w_idx      = (r_state == S_POP) ? w_idx_lo : w_idx_hi;
    assign w_mask_clr = r_mask & ~(8'd1 << w_idx);

    assign sp        = r_sp;
    assign addr_out  = r_addr;
    assign dp_immed7 = r_imm7;
    assign dp_immed8 = r_imm8;
    assign err       = r_err;

    always_comb begin
        w_idx_hi = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_mask[i]) w_idx_hi = 3'(i);
        end
    end

    always_comb begin
        w_idx_lo = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) w_idx_lo = 3'(i);
        end
    end

`ifdef ST_TIMEOUT_EN
    logic [31:0] r_tmo;

    // counts unacknowledged request cycles of the current transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= 32'd0;
        end else if (!w_xfer || mem_ack) begin
            r_tmo <= 32'd0;
        end else begin
            r_tmo <= r_tmo + 32'd1;
        end
    end

    assign w_tmo_hit = w_xfer && !mem_ack && (r_tmo == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        dp_op_sel   = 8'h00;
        dp_data_in  = r_sp;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_reg_idx = 3'd0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && w_legal) begin
                    if (op_sel == OP_PUSH && reg_list != 8'd0)     w_state_nxt = S_PUSH;
                    else if (op_sel == OP_POP && reg_list != 8'd0) w_state_nxt = S_POP;
                    else                                           w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                dp_op_sel = r_op;
                if (r_op == OP_MOVSP) dp_data_in = r_movsp;
                w_state_nxt = S_DONE;
            end
            S_PUSH: begin
                dp_op_sel   = OP_PUSH;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = dp_data_out;
                mem_reg_idx = w_idx_hi;
                if ((mem_ack && w_mask_clr == 8'd0) || w_tmo_hit) w_state_nxt = S_DONE;
            end
            S_POP: begin
                dp_op_sel   = OP_POP;
                mem_req     = 1'b1;
                mem_addr    = r_sp;
                mem_reg_idx = w_idx_lo;
                if ((mem_ack && w_mask_clr == 8'd0) || w_tmo_hit) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp    <= SP_RESET;
            r_addr  <= 32'd0;
            r_op    <= 8'h00;
            r_imm7  <= 7'd0;
            r_imm8  <= 8'd0;
            r_mask  <= 8'd0;
            r_movsp <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_tmo_hit;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_legal) begin
                            r_op    <= op_sel;
                            r_imm7  <= immed7;
                            r_imm8  <= immed8;
                            r_mask  <= reg_list;
                            r_movsp <= movsp_val;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        OP_ADDSP, OP_SUBSP, OP_MOVSP: r_sp   <= dp_data_out;
                        OP_ADDS, OP_LDRSP, OP_STRSP:  r_addr <= dp_data_out;
                        default: ;
                    endcase
                end
                S_PUSH, S_POP: begin
                    if (mem_ack) begin
                        r_sp   <= dp_data_out;
                        r_mask <= w_mask_clr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_st_sp_controller.sv
// tb/tb_st_sp_controller.sv - directed and randomized bench for st_sp_controller with datapath and SP reference model
module tb_st_sp_controller;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PUSH  = 8'h01;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_ADDSP = 8'h04;
    localparam logic [7:0] OP_SUBSP = 8'h08;
    localparam logic [7:0] OP_MOVSP = 8'h10;
    localparam logic [7:0] OP_ADDS  = 8'h20;
    localparam logic [7:0] OP_LDRSP = 8'h40;
    localparam logic [7:0] OP_STRSP = 8'h80;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  op_sel;
    logic [6:0]  immed7;
    logic [7:0]  immed8;
    logic [7:0]  reg_list;
    logic [31:0] movsp_val;
    logic [31:0] dp_data_out;
    logic [31:0] dp_data_in;
    logic [7:0]  dp_op_sel;
    logic [6:0]  dp_immed7;
    logic [7:0]  dp_immed8;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_reg_idx;
    logic        mem_ack;
    logic [31:0] sp;
    logic [31:0] addr_out;
    logic        busy;
    logic        done;
    logic        err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_sp;
    logic [31:0] m_addr;

    st_sp_controller dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
        .immed7(immed7), .immed8(immed8), .reg_list(reg_list), .movsp_val(movsp_val),
        .dp_data_out(dp_data_out), .dp_data_in(dp_data_in), .dp_op_sel(dp_op_sel),
        .dp_immed7(dp_immed7), .dp_immed8(dp_immed8),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_reg_idx(mem_reg_idx),
        .mem_ack(mem_ack), .sp(sp), .addr_out(addr_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // external combinational stack-pointer datapath
    always_comb begin
        case (dp_op_sel)
            OP_PUSH:                     dp_data_out = dp_data_in - 32'd4;
            OP_POP:                      dp_data_out = dp_data_in + 32'd4;
            OP_ADDSP:                    dp_data_out = dp_data_in + {23'd0, dp_immed7, 2'b00};
            OP_SUBSP:                    dp_data_out = dp_data_in - {23'd0, dp_immed7, 2'b00};
            OP_MOVSP:                    dp_data_out = dp_data_in;
            OP_ADDS, OP_LDRSP, OP_STRSP: dp_data_out = dp_data_in + {22'd0, dp_immed8, 2'b00};
            default:                     dp_data_out = 32'd0;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_single(input logic [7:0] op, input logic [6:0] i7,
                             input logic [7:0] i8, input logic [31:0] mv);
        case (op)
            OP_ADDSP: m_sp = m_sp + 32'(i7) * 32'd4;
            OP_SUBSP: m_sp = m_sp - 32'(i7) * 32'd4;
            OP_MOVSP: m_sp = mv;
            OP_ADDS, OP_LDRSP, OP_STRSP: m_addr = m_sp + 32'(i8) * 32'd4;
            default: ;
        endcase
        op_sel = op; immed7 = i7; immed8 = i8; movsp_val = mv; reg_list = 8'd0;
        mem_ack = 1'($urandom_range(0, 1));
        start = 1'b1;
        step();
        start = 1'b0;
        op_sel = 8'($urandom);
        chk("exec_op", dp_op_sel, op);
        chk("exec_busy", busy, 1);
        chk("exec_done", done, 0);
        chk("exec_req", mem_req, 0);
        chk("exec_imm7", dp_immed7, i7);
        if (op == OP_MOVSP) chk("exec_movsp_in", dp_data_in, mv);
        step();
        mem_ack = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_sp", sp, m_sp);
        chk("done_addr", addr_out, m_addr);
        chk("done_dpop", dp_op_sel, 0);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    // wfix < 0 selects a random ack wait per transfer
    task automatic run_list(input logic [7:0] op, input logic [7:0] list,
                            input int wfix, input logic poke_start);
        int          idx_q[$];
        logic [31:0] addr_q[$];
        int          w;
        if (op == OP_PUSH) begin
            for (int i = 7; i >= 0; i--) begin
                if (list[i]) begin
                    m_sp = m_sp - 32'd4;
                    addr_q.push_back(m_sp);
                    idx_q.push_back(i);
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (list[i]) begin
                    addr_q.push_back(m_sp);
                    idx_q.push_back(i);
                    m_sp = m_sp + 32'd4;
                end
            end
        end
        op_sel = op; reg_list = list; immed7 = 7'($urandom); immed8 = 8'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < idx_q.size(); k++) begin
            w = (wfix < 0) ? int'($urandom_range(0, 3)) : wfix;
            for (int c = 0; c <= w; c++) begin
                chk("xfer_req", mem_req, 1);
                chk("xfer_we", mem_we, (op == OP_PUSH) ? 32'd1 : 32'd0);
                chk("xfer_addr", mem_addr, addr_q[k]);
                chk("xfer_idx", mem_reg_idx, 32'(idx_q[k]));
                chk("xfer_done", done, 0);
                chk("xfer_err", err, 0);
                if (poke_start && k == 0 && c == 0) begin
                    start = 1'b1; op_sel = OP_ADDSP; immed7 = 7'h7F;
                end
                if (c == w) mem_ack = 1'b1;
                step();
                mem_ack = 1'b0;
                start = 1'b0;
            end
        end
        chk("list_done", done, 1);
        chk("list_req_low", mem_req, 0);
        chk("list_sp", sp, m_sp);
        step();
        chk("list_idle", busy, 0);
        chk("list_done_once", done, 0);
    endtask

    task automatic do_illegal(input logic [7:0] op);
        op_sel = op; immed7 = 7'($urandom); reg_list = 8'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_sp", sp, m_sp);
        step();
        chk("ill_err_clear", err, 0);
        chk("ill_busy2", busy, 0);
        chk("ill_addr", addr_out, m_addr);
    endtask

    initial begin
        logic [7:0] singles[9];
        logic [7:0] bad;
        int         r;
        singles = '{OP_NOP, OP_PUSH, OP_POP, OP_ADDSP, OP_SUBSP, OP_MOVSP, OP_ADDS, OP_LDRSP, OP_STRSP};
        reset = 1'b1; start = 1'b0; op_sel = 8'h00; immed7 = 7'd0; immed8 = 8'd0;
        reg_list = 8'd0; movsp_val = 32'd0; mem_ack = 1'b0;
        step();
        step();
        chk("rst_sp", sp, 32'h0000_1000);
        chk("rst_addr", addr_out, 0);
        chk("rst_dpop", dp_op_sel, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_idx", mem_reg_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        m_sp = 32'h0000_1000;
        m_addr = 32'd0;
        step();

        do_single(OP_ADDSP, 7'd5, 8'd0, 32'd0);
        chk("tp_addsp_sp", sp, 32'h0000_1014);
        do_single(OP_SUBSP, 7'd5, 8'd0, 32'd0);
        run_list(OP_PUSH, 8'b1000_0101, 2, 1'b0);
        chk("tp_push_sp", sp, 32'h0000_0FF4);
        run_list(OP_POP, 8'b0000_0011, 0, 1'b0);
        chk("tp_pop_sp", sp, 32'h0000_0FFC);
        do_single(OP_MOVSP, 7'd0, 8'd0, 32'h0000_0000);
        run_list(OP_PUSH, 8'h01, 1, 1'b0);
        chk("tp_wrap_sp", sp, 32'hFFFF_FFFC);
        do_single(OP_LDRSP, 7'd0, 8'd3, 32'd0);
        chk("tp_ldrsp_addr", addr_out, 32'h0000_0008);
        chk("tp_ldrsp_sp", sp, 32'hFFFF_FFFC);
        do_illegal(8'h03);
        run_list(OP_PUSH, 8'h0A, 1, 1'b1);
        do_single(OP_PUSH, 7'd3, 8'd0, 32'd0);
        do_single(OP_POP, 7'd3, 8'd0, 32'd0);

        op_sel = OP_PUSH; reg_list = 8'h0F; start = 1'b1;
        step();
        start = 1'b0;
        chk("midrst_req_before", mem_req, 1);
        step();
        reset = 1'b1;
        step();
        chk("midrst_req", mem_req, 0);
        chk("midrst_sp", sp, 32'h0000_1000);
        chk("midrst_busy", busy, 0);
        reset = 1'b0;
        m_sp = 32'h0000_1000;
        m_addr = 32'd0;
        step();

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 11);
            if (r <= 8) begin
                do_single(singles[r], 7'($urandom), 8'($urandom), $urandom);
            end else if (r == 9) begin
                run_list(OP_PUSH, 8'($urandom_range(1, 255)), -1, 1'($urandom_range(0, 1)));
            end else if (r == 10) begin
                run_list(OP_POP, 8'($urandom_range(1, 255)), -1, 1'($urandom_range(0, 1)));
            end else begin
                bad = 8'($urandom);
                while ($countones(bad) < 2) bad = 8'($urandom);
                do_illegal(bad);
            end
        end

`ifdef ST_TIMEOUT_EN
        do_single(OP_MOVSP, 7'd0, 8'd0, 32'h0000_1000);
        op_sel = OP_PUSH; reg_list = 8'h03; start = 1'b1;
        step();
        start = 1'b0;
        chk("tmo_idx1", mem_reg_idx, 1);
        chk("tmo_addr1", mem_addr, 32'h0000_0FFC);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("tmo_idx0", mem_reg_idx, 0);
        chk("tmo_addr0", mem_addr, 32'h0000_0FF8);
        for (int j = 0; j < 16; j++) begin
            chk("tmo_wait_req", mem_req, 1);
            chk("tmo_wait_err", err, 0);
            step();
        end
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        chk("tmo_req", mem_req, 0);
        chk("tmo_sp", sp, 32'h0000_0FFC);
        step();
        chk("tmo_err_clear", err, 0);
        chk("tmo_idle", busy, 0);
        m_sp = 32'h0000_0FFC;
`else
        run_list(OP_PUSH, 8'h01, 40, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
